// File: rtl/bp_history_trainq_if.sv
// Bus bundle between the perceptron front-end controller and its fetch,
// predictor and branch-resolution neighbours.
interface bp_history_trainq_if #(
  parameter int unsigned HIST     = 28,
  parameter int unsigned TAG_BITS = 3
);
  logic                fe_valid;
  logic [31:0]         fe_pc;
  logic                fe_ready;
  logic                fe_pred_valid;
  logic                fe_pred_taken;
  logic [TAG_BITS-1:0] fe_pred_tag;
  logic                p_req_valid;
  logic [31:0]         p_req_pc;
  logic [HIST-1:0]     p_req_ghr;
  logic                p_req_ready;
  logic                p_pred_valid;
  logic                p_pred_taken;
  logic                p_train_valid;
  logic [31:0]         p_train_pc;
  logic                p_train_taken;
  logic [HIST-1:0]     p_train_ghr;
  logic                p_train_ready;
  logic                rs_valid;
  logic                rs_taken;
  logic                rs_ready;
  logic                rs_mispredict;
  logic [HIST-1:0]     spec_ghr;
  logic [HIST-1:0]     arch_ghr;

  modport master (
    output fe_valid, fe_pc, p_req_ready, p_pred_valid, p_pred_taken,
           p_train_ready, rs_valid, rs_taken,
    input  fe_ready, fe_pred_valid, fe_pred_taken, fe_pred_tag, p_req_valid,
           p_req_pc, p_req_ghr, p_train_valid, p_train_pc, p_train_taken,
           p_train_ghr, rs_ready, rs_mispredict, spec_ghr, arch_ghr
  );

  modport slave (
    input  fe_valid, fe_pc, p_req_ready, p_pred_valid, p_pred_taken,
           p_train_ready, rs_valid, rs_taken,
    output fe_ready, fe_pred_valid, fe_pred_taken, fe_pred_tag, p_req_valid,
           p_req_pc, p_req_ghr, p_train_valid, p_train_pc, p_train_taken,
           p_train_ghr, rs_ready, rs_mispredict, spec_ghr, arch_ghr
  );
endinterface

// File: rtl/bp_history_trainq.sv
// Perceptron front-end controller: speculative/architectural GHRs, in-order
// in-flight branch FIFO, training queue, and mispredict repair.
module bp_history_trainq #(
  parameter int unsigned HIST     = 28,
  parameter int unsigned IF_DEPTH = 8,
  parameter int unsigned TQ_DEPTH = 4,
  parameter int unsigned TAG_BITS = $clog2(IF_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  bp_history_trainq_if.slave bus
);
  localparam int unsigned IF_CW = $clog2(IF_DEPTH + 1);
  localparam int unsigned TQ_PW = $clog2(TQ_DEPTH);
  localparam int unsigned TQ_CW = $clog2(TQ_DEPTH + 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_PRED = 2'd1;
  localparam logic [1:0] S_WAIT_DROP = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [HIST-1:0]     spec_q, spec_d, arch_q, arch_d, snap_ghr_q, snap_ghr_d;
  logic [31:0]         snap_pc_q, snap_pc_d;
  logic [TAG_BITS-1:0] if_wr_q, if_wr_d, if_rd_q, if_rd_d;
  logic [IF_CW-1:0]    if_cnt_q, if_cnt_d;
  logic [TQ_PW-1:0]    tq_wr_q, tq_wr_d, tq_rd_q, tq_rd_d;
  logic [TQ_CW-1:0]    tq_cnt_q, tq_cnt_d;

  logic [31:0]     if_pc_mem   [IF_DEPTH];
  logic [HIST-1:0] if_ghr_mem  [IF_DEPTH];
  logic            if_pred_mem [IF_DEPTH];
  logic [31:0]     tq_pc_mem   [TQ_DEPTH];
  logic [HIST-1:0] tq_ghr_mem  [TQ_DEPTH];
  logic            tq_tkn_mem  [TQ_DEPTH];

  logic if_full, tq_full, tq_nonempty, train_sel, req_valid, req_fire, train_fire;
  logic rs_rdy, rs_fire, misp, pred_fire;

  // Arbitration: training drains when fetch is idle or either queue backs up.
  always_comb begin
    if_full     = (if_cnt_q == IF_CW'(IF_DEPTH));
    tq_full     = (tq_cnt_q == TQ_CW'(TQ_DEPTH));
    tq_nonempty = (tq_cnt_q != '0);
    train_sel   = (state_q == S_IDLE) && tq_nonempty && (!bus.fe_valid || tq_full || if_full);
    req_valid   = (state_q == S_IDLE) && bus.fe_valid && !train_sel && !if_full;
    req_fire    = req_valid && bus.p_req_ready;
    train_fire  = train_sel && bus.p_train_ready;
    rs_rdy      = (if_cnt_q != '0) && !tq_full;
    rs_fire     = bus.rs_valid && rs_rdy;
    misp        = rs_fire && (bus.rs_taken != if_pred_mem[if_rd_q]);
    pred_fire   = (state_q == S_WAIT_PRED) && bus.p_pred_valid && !misp;
  end

  always_comb begin
    state_d    = state_q;
    spec_d     = spec_q;
    arch_d     = arch_q;
    snap_pc_d  = snap_pc_q;
    snap_ghr_d = snap_ghr_q;
    if_wr_d    = if_wr_q;
    if_rd_d    = if_rd_q;
    if_cnt_d   = if_cnt_q;
    tq_wr_d    = tq_wr_q;
    tq_rd_d    = tq_rd_q;
    tq_cnt_d   = tq_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (req_fire) begin
          state_d    = S_WAIT_PRED;
          snap_pc_d  = bus.fe_pc;
          snap_ghr_d = spec_q;
        end
      end
      S_WAIT_PRED: begin
        if (bus.p_pred_valid) state_d = S_IDLE;
        else if (misp)        state_d = S_WAIT_DROP;
      end
      S_WAIT_DROP: begin
        if (bus.p_pred_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (pred_fire) begin
      if_wr_d = if_wr_q + TAG_BITS'(1);
      spec_d  = {spec_q[HIST-2:0], bus.p_pred_taken};
    end

    // A mispredict discards every younger in-flight branch and rebuilds spec history.
    if (misp) begin
      if_rd_d  = if_wr_q;
      if_cnt_d = '0;
      spec_d   = {arch_q[HIST-2:0], bus.rs_taken};
    end else if (rs_fire) begin
      if_rd_d = if_rd_q + TAG_BITS'(1);
      if (!pred_fire) if_cnt_d = if_cnt_q - IF_CW'(1);
    end else if (pred_fire) begin
      if_cnt_d = if_cnt_q + IF_CW'(1);
    end

    if (rs_fire) begin
      arch_d  = {arch_q[HIST-2:0], bus.rs_taken};
      tq_wr_d = tq_wr_q + TQ_PW'(1);
    end
    if (train_fire) tq_rd_d = tq_rd_q + TQ_PW'(1);
    if (rs_fire && !train_fire)      tq_cnt_d = tq_cnt_q + TQ_CW'(1);
    else if (train_fire && !rs_fire) tq_cnt_d = tq_cnt_q - TQ_CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      spec_q     <= '0;
      arch_q     <= '0;
      snap_pc_q  <= '0;
      snap_ghr_q <= '0;
      if_wr_q    <= '0;
      if_rd_q    <= '0;
      if_cnt_q   <= '0;
      tq_wr_q    <= '0;
      tq_rd_q    <= '0;
      tq_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      spec_q     <= spec_d;
      arch_q     <= arch_d;
      snap_pc_q  <= snap_pc_d;
      snap_ghr_q <= snap_ghr_d;
      if_wr_q    <= if_wr_d;
      if_rd_q    <= if_rd_d;
      if_cnt_q   <= if_cnt_d;
      tq_wr_q    <= tq_wr_d;
      tq_rd_q    <= tq_rd_d;
      tq_cnt_q   <= tq_cnt_d;
    end
  end

  // Payload storage carries no reset; occupancy is tracked by the counters.
  always_ff @(posedge clk) begin
    if (pred_fire) begin
      if_pc_mem[if_wr_q]   <= snap_pc_q;
      if_ghr_mem[if_wr_q]  <= snap_ghr_q;
      if_pred_mem[if_wr_q] <= bus.p_pred_taken;
    end
    if (rs_fire) begin
      tq_pc_mem[tq_wr_q]  <= if_pc_mem[if_rd_q];
      tq_ghr_mem[tq_wr_q] <= if_ghr_mem[if_rd_q];
      tq_tkn_mem[tq_wr_q] <= bus.rs_taken;
    end
  end

  // Every output is forced low while reset is asserted.
  assign bus.fe_ready      = !rst && req_fire;
  assign bus.fe_pred_valid = !rst && pred_fire;
  assign bus.fe_pred_taken = !rst && pred_fire && bus.p_pred_taken;
  assign bus.fe_pred_tag   = rst ? '0 : if_wr_q;
  assign bus.p_req_valid   = !rst && req_valid;
  assign bus.p_req_pc      = rst ? '0 : bus.fe_pc;
  assign bus.p_req_ghr     = rst ? '0 : spec_q;
  assign bus.p_train_valid = !rst && train_sel;
  assign bus.p_train_pc    = rst ? '0 : tq_pc_mem[tq_rd_q];
  assign bus.p_train_taken = !rst && tq_tkn_mem[tq_rd_q];
  assign bus.p_train_ghr   = rst ? '0 : tq_ghr_mem[tq_rd_q];
  assign bus.rs_ready      = !rst && rs_rdy;
  assign bus.rs_mispredict = !rst && misp;
  assign bus.spec_ghr      = rst ? '0 : spec_q;
  assign bus.arch_ghr      = rst ? '0 : arch_q;
endmodule

// File: tb/tb_bp_history_trainq.sv
// Directed vector bench for bp_history_trainq: table of single-cycle vectors
// plus looped sequences for FIFO-full and training-queue-full corners.
module tb_bp_history_trainq;
  localparam int unsigned HIST = 28;
  localparam int unsigned TAGB = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bp_history_trainq_if #(.HIST(HIST), .TAG_BITS(TAGB)) bus ();

  bp_history_trainq #(.HIST(HIST), .IF_DEPTH(8), .TQ_DEPTH(4), .TAG_BITS(TAGB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // comb bits: {fe_ready, p_req_valid, fe_pred_valid, p_train_valid, rs_ready, rs_mispredict}
  typedef struct {
    logic            r_rst;
    logic            fv;
    logic [31:0]     pc;
    logic            pv;
    logic            pt;
    logic            trdy;
    logic            rsv;
    logic            rtk;
    logic [5:0]      comb;
    logic [TAGB-1:0] tag;
    logic [31:0]     trpc;
    logic [HIST-1:0] trghr;
    logic            trtk;
    logic [HIST-1:0] spec;
    logic [HIST-1:0] arch;
  } vec_t;

  int checks = 0;
  int failures = 0;
  logic [HIST-1:0] cur_spec = '0;
  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic fv, input logic [31:0] pc,
                              input logic pv, input logic pt, input logic trdy,
                              input logic rsv, input logic rtk, input logic [5:0] comb,
                              input logic [TAGB-1:0] tag, input logic [31:0] trpc,
                              input logic [HIST-1:0] trghr, input logic trtk,
                              input logic [HIST-1:0] spec, input logic [HIST-1:0] arch);
    vec_t v;
    v.r_rst = r; v.fv = fv; v.pc = pc; v.pv = pv; v.pt = pt; v.trdy = trdy;
    v.rsv = rsv; v.rtk = rtk; v.comb = comb; v.tag = tag; v.trpc = trpc;
    v.trghr = trghr; v.trtk = trtk; v.spec = spec; v.arch = arch;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input string id, input vec_t v);
    @(negedge clk);
    rst               = v.r_rst;
    bus.fe_valid      = v.fv;
    bus.fe_pc         = v.pc;
    bus.p_req_ready   = 1'b1;
    bus.p_pred_valid  = v.pv;
    bus.p_pred_taken  = v.pt;
    bus.p_train_ready = v.trdy;
    bus.rs_valid      = v.rsv;
    bus.rs_taken      = v.rtk;
    #2;
    chk({id, ".comb"}, 64'({bus.fe_ready, bus.p_req_valid, bus.fe_pred_valid,
                            bus.p_train_valid, bus.rs_ready, bus.rs_mispredict}), 64'(v.comb));
    chk({id, ".tag"}, 64'(bus.fe_pred_tag), 64'(v.tag));
    if (v.comb[4]) begin
      chk({id, ".req_pc"}, 64'(bus.p_req_pc), 64'(v.pc));
      chk({id, ".req_ghr"}, 64'(bus.p_req_ghr), 64'(cur_spec));
    end
    if (v.comb[3]) chk({id, ".pred_taken"}, 64'(bus.fe_pred_taken), 64'(v.pt));
    if (v.comb[2]) begin
      chk({id, ".train_pc"}, 64'(bus.p_train_pc), 64'(v.trpc));
      chk({id, ".train_ghr"}, 64'(bus.p_train_ghr), 64'(v.trghr));
      chk({id, ".train_taken"}, 64'(bus.p_train_taken), 64'(v.trtk));
    end
    @(posedge clk);
    #1;
    chk({id, ".spec_ghr"}, 64'(bus.spec_ghr), 64'(v.spec));
    chk({id, ".arch_ghr"}, 64'(bus.arch_ghr), 64'(v.arch));
    cur_spec = v.spec;
  endtask

  initial begin
    bus.fe_valid = 1'b0; bus.fe_pc = '0; bus.p_req_ready = 1'b1;
    bus.p_pred_valid = 1'b0; bus.p_pred_taken = 1'b0; bus.p_train_ready = 1'b0;
    bus.rs_valid = 1'b0; bus.rs_taken = 1'b0;

    //             rst fv pc         pv pt tr rv rt comb       tag trpc       trghr trtk spec   arch
    tbl.push_back(mk(1, 1, 32'h0,   0, 0, 1, 1, 0, 6'b000000, 0, 32'h0,     0, 0, 28'h0, 28'h0));
    tbl.push_back(mk(1, 1, 32'h0,   0, 0, 1, 1, 0, 6'b000000, 0, 32'h0,     0, 0, 28'h0, 28'h0));
    // first predict, resolve correct, drain training
    tbl.push_back(mk(0, 1, 32'h100, 0, 0, 1, 0, 0, 6'b110000, 0, 32'h0,     0, 0, 28'h0, 28'h0));
    tbl.push_back(mk(0, 0, 32'h0,   1, 1, 1, 0, 0, 6'b001000, 0, 32'h0,     0, 0, 28'h1, 28'h0));
    tbl.push_back(mk(0, 0, 32'h0,   0, 0, 1, 1, 1, 6'b000010, 1, 32'h0,     0, 0, 28'h1, 28'h1));
    tbl.push_back(mk(0, 0, 32'h0,   0, 0, 1, 0, 0, 6'b000100, 1, 32'h100,   0, 1, 28'h1, 28'h1));
    // three taken predictions then a not-taken resolve of the oldest
    tbl.push_back(mk(1, 1, 32'h0,   0, 0, 1, 0, 0, 6'b000000, 0, 32'h0,     0, 0, 28'h0, 28'h0));
    tbl.push_back(mk(0, 1, 32'h200, 0, 0, 1, 0, 0, 6'b110000, 0, 32'h0,     0, 0, 28'h0, 28'h0));
    tbl.push_back(mk(0, 0, 32'h0,   1, 1, 1, 0, 0, 6'b001000, 0, 32'h0,     0, 0, 28'h1, 28'h0));
    tbl.push_back(mk(0, 1, 32'h204, 0, 0, 1, 0, 0, 6'b110010, 1, 32'h0,     0, 0, 28'h1, 28'h0));
    tbl.push_back(mk(0, 0, 32'h0,   1, 1, 1, 0, 0, 6'b001010, 1, 32'h0,     0, 0, 28'h3, 28'h0));
    tbl.push_back(mk(0, 1, 32'h208, 0, 0, 1, 0, 0, 6'b110010, 2, 32'h0,     0, 0, 28'h3, 28'h0));
    tbl.push_back(mk(0, 0, 32'h0,   1, 1, 1, 0, 0, 6'b001010, 2, 32'h0,     0, 0, 28'h7, 28'h0));
    tbl.push_back(mk(0, 0, 32'h0,   0, 0, 1, 1, 0, 6'b000011, 3, 32'h0,     0, 0, 28'h0, 28'h0));
    tbl.push_back(mk(0, 0, 32'h0,   0, 0, 1, 0, 0, 6'b000100, 3, 32'h200,   0, 0, 28'h0, 28'h0));
    // mispredict while waiting, late prediction dropped
    tbl.push_back(mk(0, 1, 32'h300, 0, 0, 1, 0, 0, 6'b110000, 3, 32'h0,     0, 0, 28'h0, 28'h0));
    tbl.push_back(mk(0, 0, 32'h0,   1, 1, 1, 0, 0, 6'b001000, 3, 32'h0,     0, 0, 28'h1, 28'h0));
    tbl.push_back(mk(0, 1, 32'h304, 0, 0, 1, 0, 0, 6'b110010, 4, 32'h0,     0, 0, 28'h1, 28'h0));
    tbl.push_back(mk(0, 0, 32'h0,   0, 0, 1, 1, 0, 6'b000011, 4, 32'h0,     0, 0, 28'h0, 28'h0));
    tbl.push_back(mk(0, 0, 32'h0,   1, 1, 1, 0, 0, 6'b000000, 4, 32'h0,     0, 0, 28'h0, 28'h0));
    tbl.push_back(mk(0, 0, 32'h0,   0, 0, 1, 0, 0, 6'b000100, 4, 32'h300,   0, 0, 28'h0, 28'h0));
    // mispredict in the same cycle as the prediction
    tbl.push_back(mk(0, 1, 32'h400, 0, 0, 1, 0, 0, 6'b110000, 4, 32'h0,     0, 0, 28'h0, 28'h0));
    tbl.push_back(mk(0, 0, 32'h0,   1, 1, 1, 0, 0, 6'b001000, 4, 32'h0,     0, 0, 28'h1, 28'h0));
    tbl.push_back(mk(0, 1, 32'h404, 0, 0, 1, 0, 0, 6'b110010, 5, 32'h0,     0, 0, 28'h1, 28'h0));
    tbl.push_back(mk(0, 0, 32'h0,   1, 1, 1, 1, 0, 6'b000011, 5, 32'h0,     0, 0, 28'h0, 28'h0));
    tbl.push_back(mk(0, 0, 32'h0,   0, 0, 1, 0, 0, 6'b000100, 5, 32'h400,   0, 0, 28'h0, 28'h0));

    foreach (tbl[i]) run_vec($sformatf("v%0d", i), tbl[i]);

    // Fill the in-flight FIFO with eight taken predictions; tags wrap from 5.
    for (int k = 0; k < 8; k++) begin
      run_vec($sformatf("fill_req%0d", k),
              mk(0, 1, 32'h500 + 32'(4 * k), 0, 0, 1, 0, 0, {4'b1100, (k != 0), 1'b0},
                 TAGB'(5 + k), 32'h0, 0, 0, 28'((1 << k) - 1), 28'h0));
      run_vec($sformatf("fill_pred%0d", k),
              mk(0, 0, 32'h0, 1, 1, 1, 0, 0, {4'b0010, (k != 0), 1'b0},
                 TAGB'(5 + k), 32'h0, 0, 0, 28'((1 << (k + 1)) - 1), 28'h0));
    end
    run_vec("if_full",  mk(0, 1, 32'h5F0, 0, 0, 1, 0, 0, 6'b000010, 5, 32'h0, 0, 0, 28'hFF,  28'h0));
    run_vec("res_full", mk(0, 1, 32'h5F0, 0, 0, 1, 1, 1, 6'b000010, 5, 32'h0, 0, 0, 28'hFF,  28'h1));
    run_vec("req_600",  mk(0, 1, 32'h600, 0, 0, 1, 0, 0, 6'b110010, 5, 32'h0, 0, 0, 28'hFF,  28'h1));
    run_vec("pred_res", mk(0, 0, 32'h0,   1, 1, 1, 1, 1, 6'b001010, 5, 32'h0, 0, 0, 28'h1FF, 28'h3));
    run_vec("req_700",  mk(0, 1, 32'h700, 0, 0, 1, 0, 0, 6'b110010, 6, 32'h0, 0, 0, 28'h1FF, 28'h3));
    run_vec("pred_700", mk(0, 0, 32'h0,   1, 1, 1, 0, 0, 6'b001010, 6, 32'h0, 0, 0, 28'h3FF, 28'h3));
    run_vec("refull",   mk(0, 1, 32'h7F0, 0, 0, 0, 0, 0, 6'b000110, 7, 32'h500, 0, 1, 28'h3FF, 28'h3));

    // Fill the training queue with the predictor stalled, then release it.
    run_vec("tq_fill3", mk(0, 0, 32'h0,   0, 0, 0, 1, 1, 6'b000110, 7, 32'h500, 0, 1, 28'h3FF, 28'h7));
    run_vec("tq_fill4", mk(0, 0, 32'h0,   0, 0, 0, 1, 1, 6'b000110, 7, 32'h500, 0, 1, 28'h3FF, 28'hF));
    run_vec("tq_full",  mk(0, 1, 32'h800, 0, 0, 0, 1, 1, 6'b000100, 7, 32'h500, 0, 1, 28'h3FF, 28'hF));
    run_vec("trn_wins", mk(0, 1, 32'h800, 0, 0, 1, 0, 0, 6'b000100, 7, 32'h500, 0, 1, 28'h3FF, 28'hF));
    run_vec("req_800",  mk(0, 1, 32'h800, 0, 0, 1, 0, 0, 6'b110010, 7, 32'h0,   0, 0, 28'h3FF, 28'hF));
    run_vec("pred_nt",  mk(0, 0, 32'h0,   1, 0, 1, 0, 0, 6'b001010, 7, 32'h0,   0, 0, 28'h7FE, 28'hF));
    run_vec("trn_504",  mk(0, 0, 32'h0,   0, 0, 1, 0, 0, 6'b000110, 0, 32'h504, 1, 1, 28'h7FE, 28'hF));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
